meas_hex_uart: RTL and testbench

//   Serialises one 40-bit TDC measurement (clock-cycle count) as a human-readable

---
 rtl/meas_hex_uart.sv | 141 ++++++++++++++
 tb/tb_meas_hex_uart.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/meas_hex_uart.sv
// Sends one 40-bit measurement as 10 uppercase ASCII hex digits (MSB nibble first),
// optionally followed by CR LF, over an 8N1 UART with bytes sent back to back.
module meas_hex_uart #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 115200,
  parameter bit ADD_CRLF = 1'b1
) (
  input  logic        clk_100m,
  input  logic        rst_n,
  input  logic [39:0] data,
  input  logic        data_valid,
  output logic        tx,
  output logic        busy
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int NUM_BYTES    = ADD_CRLF ? 12 : 10;
  localparam int BAUD_W       = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $error("meas_hex_uart: CLKS_PER_BIT must be >= 2");
  end

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t              state_q, state_d;
  logic [BAUD_W-1:0]   baud_cnt_q, baud_cnt_d;
  logic [3:0]          bit_cnt_q, bit_cnt_d;
  logic [3:0]          byte_cnt_q, byte_cnt_d;
  logic [39:0]         shadow_q, shadow_d;
  logic [7:0]          shift_q, shift_d;
  logic                tx_q, tx_d;
  logic                busy_q, busy_d;
  logic                bit_end;
  logic                last_byte;

  // Byte idx of the frame: hex digit of nibble idx (MSB first), then CR, LF.
  function automatic logic [7:0] frame_byte(input logic [39:0] val, input logic [3:0] idx);
    logic [3:0] nib;
    nib = 4'(val >> (6'd36 - {idx, 2'b00}));
    if (idx == 4'd10) begin
      return 8'h0D;
    end else if (idx == 4'd11) begin
      return 8'h0A;
    end else if (nib <= 4'd9) begin
      return 8'h30 + {4'h0, nib};
    end else begin
      return 8'h37 + {4'h0, nib};
    end
  endfunction

  assign bit_end   = (baud_cnt_q == BAUD_W'(CLKS_PER_BIT - 1));
  assign last_byte = (byte_cnt_q == 4'(NUM_BYTES - 1));

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    shadow_d   = shadow_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    busy_d     = busy_q;

    if (state_q == IDLE) begin
      // Byte 0 is encoded straight from the input since the shadow loads on this edge.
      if (data_valid) begin
        state_d    = START;
        shadow_d   = data;
        shift_d    = frame_byte(data, 4'd0);
        baud_cnt_d = '0;
        bit_cnt_d  = 4'd0;
        byte_cnt_d = 4'd0;
        tx_d       = 1'b0;
        busy_d     = 1'b1;
      end
    end else begin
      baud_cnt_d = bit_end ? '0 : baud_cnt_q + 1'b1;
      if (bit_end) begin
        case (state_q)
          START: begin
            state_d   = DATA;
            bit_cnt_d = 4'd1;
            tx_d      = shift_q[0];
          end
          DATA: begin
            if (bit_cnt_q == 4'd8) begin
              state_d   = STOP;
              bit_cnt_d = 4'd9;
              tx_d      = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
              shift_d   = shift_q >> 1;
              tx_d      = shift_q[1];
            end
          end
          STOP: begin
            bit_cnt_d = 4'd0;
            if (last_byte) begin
              state_d = IDLE;
              busy_d  = 1'b0;
              tx_d    = 1'b1;
            end else begin
              state_d    = START;
              byte_cnt_d = byte_cnt_q + 4'd1;
              shift_d    = frame_byte(shadow_q, byte_cnt_q + 4'd1);
              tx_d       = 1'b0;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= 4'd0;
      byte_cnt_q <= 4'd0;
      shadow_q   <= 40'd0;
      shift_q    <= 8'd0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      shadow_q   <= shadow_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_meas_hex_uart.sv
// Bench for meas_hex_uart: two instances (with and without CR LF), a UART decoder
// per instance checking bytes against a scoreboard fed by an ASCII-level model.
module tb_meas_hex_uart;

  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 100_000;
  localparam int CPB      = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [39:0] data0, data1;
  logic        dv0, dv1;
  logic        tx0, tx1, busy0, busy1;

  always #5 clk = ~clk;

  meas_hex_uart #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .ADD_CRLF(1'b1)) u_dut0 (
    .clk_100m(clk), .rst_n(rst_n), .data(data0), .data_valid(dv0), .tx(tx0), .busy(busy0)
  );

  meas_hex_uart #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .ADD_CRLF(1'b0)) u_dut1 (
    .clk_100m(clk), .rst_n(rst_n), .data(data1), .data_valid(dv1), .tx(tx1), .busy(busy1)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          free_at[2];
  logic [7:0]  q0[$];
  logic [7:0]  q1[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name, input longint act, input longint exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic get_tx(input int id);
    return (id == 0) ? tx0 : tx1;
  endfunction

  function automatic logic get_busy(input int id);
    return (id == 0) ? busy0 : busy1;
  endfunction

  function automatic int frame_len(input int id);
    return (id == 0) ? 12 : 10;
  endfunction

  function automatic void push_exp(input int id, input logic [7:0] b);
    if (id == 0) q0.push_back(b);
    else q1.push_back(b);
  endfunction

  function automatic bit pop_exp(input int id, output logic [7:0] b);
    b = 8'h00;
    if (id == 0) begin
      if (q0.size() == 0) return 1'b0;
      b = q0.pop_front();
    end else begin
      if (q1.size() == 0) return 1'b0;
      b = q1.pop_front();
    end
    return 1'b1;
  endfunction

  // Reference: the text a terminal should show, built character by character.
  function automatic void push_frame(input int id, input logic [39:0] v);
    string      hexd;
    logic [3:0] n;
    hexd = "0123456789ABCDEF";
    for (int k = 0; k < 10; k++) begin
      n = v[39 - 4*k -: 4];
      push_exp(id, hexd[n]);
    end
    if (id == 0) begin
      push_exp(id, 8'h0D);
      push_exp(id, 8'h0A);
    end
  endfunction

  // Caller is just past a negedge; the request is seen at the next rising edge.
  task automatic send(input int id, input logic [39:0] v);
    int e;
    bit acc;
    e   = cyc + 1;
    acc = (e >= free_at[id]);
    if (id == 0) begin data0 = v; dv0 = 1'b1; end
    else begin data1 = v; dv1 = 1'b1; end
    if (acc) begin
      push_frame(id, v);
      free_at[id] = e + frame_len(id) * 10 * CPB + 1;
    end
    $display("send dut%0d value %010h %s", id, v, acc ? "accepted" : "ignored");
    @(negedge clk);
    if (id == 0) begin data0 = 40'({$urandom, $urandom}); dv0 = 1'b0; end
    else begin data1 = 40'({$urandom, $urandom}); dv1 = 1'b0; end
    check(get_busy(id) == 1'b1, "busy_after_request", get_busy(id), 1);
    if (acc) check(get_tx(id) == 1'b0, "start_bit_latency", get_tx(id), 0);
  endtask

  task automatic wait_idle(input int id);
    int n;
    n = 0;
    while (get_busy(id) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check(!get_busy(id), "idle_timeout", get_busy(id), 0);
  endtask

  task automatic uart_mon(input int id);
    forever begin
      logic       samp[100];
      logic [7:0] got, exp_b;
      bit         aborted;
      int         bad;
      logic       e;
      @(negedge clk);
      if (rst_n && get_tx(id) == 1'b0) begin
        samp[0] = 1'b0;
        aborted = 1'b0;
        for (int s = 1; s < 100; s++) begin
          @(negedge clk);
          if (!rst_n) begin
            aborted = 1'b1;
            break;
          end
          samp[s] = get_tx(id);
        end
        if (!aborted) begin
          for (int i = 0; i < 8; i++) got[i] = samp[10*(i+1) + 5];
          bad = 0;
          for (int s = 0; s < 100; s++) begin
            if (s < 10) e = 1'b0;
            else if (s >= 90) e = 1'b1;
            else e = got[s/10 - 1];
            if (samp[s] !== e) bad++;
          end
          check(bad == 0, "bit_timing", bad, 0);
          if (pop_exp(id, exp_b)) check(got == exp_b, "uart_byte", got, exp_b);
          else check(1'b0, "unexpected_byte", got, 0);
          $display("uart dut%0d byte %02h", id, got);
        end
      end
    end
  endtask

  initial uart_mon(0);
  initial uart_mon(1);

  // Every uninterrupted busy pulse must last exactly one frame.
  initial begin
    int   blen[2];
    bit   babort[2];
    logic bprev[2];
    logic b;
    bprev[0] = 1'b0; bprev[1] = 1'b0;
    blen[0] = 0; blen[1] = 0;
    babort[0] = 1'b0; babort[1] = 1'b0;
    forever begin
      @(negedge clk);
      for (int id = 0; id < 2; id++) begin
        b = get_busy(id);
        if (!rst_n) babort[id] = 1'b1;
        if (b) begin
          if (!bprev[id]) begin
            blen[id]   = 0;
            babort[id] = 1'b0;
          end
          blen[id]++;
        end else if (bprev[id] && !babort[id]) begin
          check(blen[id] == frame_len(id) * 10 * CPB, "busy_length", blen[id], frame_len(id) * 10 * CPB);
        end
        bprev[id] = b;
      end
    end
  end

  initial begin
    bit          ok;
    int          id;
    logic [39:0] v;
    rst_n = 1'b0;
    dv0 = 1'b0; dv1 = 1'b0;
    data0 = 40'd0; data1 = 40'd0;
    free_at[0] = 0; free_at[1] = 0;

    repeat (5) @(negedge clk);
    check(tx0 == 1'b1, "reset_tx0", tx0, 1);
    check(busy0 == 1'b0, "reset_busy0", busy0, 0);
    check(tx1 == 1'b1, "reset_tx1", tx1, 1);
    check(busy1 == 1'b0, "reset_busy1", busy1, 0);
    rst_n = 1'b1;
    ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (!(tx0 && tx1 && !busy0 && !busy1)) ok = 1'b0;
    end
    check(ok, "idle_after_reset", ok, 1);

    send(0, 40'h00_0000_01F4);
    wait_idle(0);
    send(0, 40'hFF_FFFF_FFFF);
    wait_idle(0);
    send(0, 40'h00_0000_0000);
    wait_idle(0);

    send(0, 40'h12_3456_789A);
    repeat (49) @(negedge clk);
    send(0, 40'h55_AA55_AA55);
    wait_idle(0);
    repeat (30) @(negedge clk);
    check(q0.size() == 0, "ignored_request_drain", q0.size(), 0);

    // Abort in byte 3, data bit 4, then a clean frame after release.
    send(0, 40'hC3_5A96_E1B7);
    repeat (344) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check(tx0 == 1'b1, "async_reset_tx", tx0, 1);
    check(busy0 == 1'b0, "async_reset_busy", busy0, 0);
    repeat (3) @(negedge clk);
    q0.delete();
    free_at[0] = 0; free_at[1] = 0;
    rst_n = 1'b1;
    @(negedge clk);
    check(tx0 == 1'b1, "tx_idle_after_abort", tx0, 1);
    send(0, 40'h0F_1E2D_3C4B);
    wait_idle(0);

    send(1, 40'hAB_CDEF_0123);
    wait_idle(1);
    send(1, 40'h98_7654_3210);
    wait_idle(1);

    for (int i = 0; i < 6; i++) begin
      id = int'($urandom_range(0, 1));
      v  = 40'({$urandom, $urandom});
      send(id, v);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 1300)) @(negedge clk);
        send(id, 40'({$urandom, $urandom}));
      end
      wait_idle(id);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    send(0, 40'({$urandom, $urandom}));
    send(1, 40'({$urandom, $urandom}));
    wait_idle(0);
    wait_idle(1);

    repeat (30) @(negedge clk);
    check(q0.size() == 0, "final_drain0", q0.size(), 0);
    check(q1.size() == 0, "final_drain1", q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
